// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over imem req/ack, presents inst/op/func to the decoder.
// Latency: inst_valid one cycle after imem_ack; with FETCH_PREFETCH_EN one instruction per cycle.
// Backpressure: imem_req/imem_addr held until imem_ack; inst/pc hold until inst_ready retires.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    input  logic [1:0]  pcsource,
    input  logic [31:0] ra_data,
    output logic        addr_err,
    output logic [31:0] icount
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_VALID = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        retire;
    logic        ack_acc;

    assign pc4        = pc + 32'd4;
    assign op         = inst[31:26];
    assign func       = inst[5:0];
    assign inst_valid = (state == S_VALID);
    assign retire     = inst_valid & inst_ready;
    assign ack_acc    = imem_req & imem_ack;
    assign br_off     = {{14{inst[15]}}, inst[15:0], 2'b00};

    always_comb begin
        next_pc = pc4;
        case (pcsource)
            2'b01:   next_pc = pc4 + br_off;
            2'b10:   next_pc = {ra_data[31:2], 2'b00};
            2'b11:   next_pc = {pc4[31:28], inst[25:0], 2'b00};
            default: next_pc = pc4;
        endcase
    end

`ifdef FETCH_PREFETCH_EN
    logic        pf_vld;
    logic [31:0] pf_dat;
    logic [31:0] drain_addr;
    logic        redirect;

    assign redirect = (pcsource != 2'b00);

    // In S_VALID the idle fetch port speculatively fetches pc+4 into the buffer.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            S_FETCH: imem_req = 1'b1;
            S_VALID: begin
                imem_req  = ~pf_vld;
                imem_addr = pc4;
            end
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default: imem_req = 1'b0;
        endcase
        if (rst)
            imem_req = 1'b0;
    end
`else
    assign imem_req  = ~rst & ((state == S_FETCH) | (state == S_DRAIN));
    assign imem_addr = pc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            inst       <= 32'd0;
            addr_err   <= 1'b0;
            icount     <= 32'd0;
`ifdef FETCH_PREFETCH_EN
            pf_vld     <= 1'b0;
            pf_dat     <= 32'd0;
            drain_addr <= RESET_PC;
`endif
        end else begin
            if (retire) begin
                icount <= icount + 32'd1;
                if (pcsource == 2'b10 && ra_data[1:0] != 2'b00)
                    addr_err <= 1'b1;
            end
            case (state)
                S_FETCH: begin
                    if (ack_acc) begin
                        inst  <= imem_rdata;
                        state <= S_VALID;
                    end
                end
                S_VALID: begin
`ifdef FETCH_PREFETCH_EN
                    if (retire) begin
                        pc <= next_pc;
                        if (!redirect && pf_vld) begin
                            inst   <= pf_dat;
                            pf_vld <= 1'b0;
                        end else if (!redirect && ack_acc) begin
                            inst <= imem_rdata;
                        end else begin
                            // A redirect with an unanswered request must still consume its ack.
                            pf_vld     <= 1'b0;
                            drain_addr <= imem_addr;
                            state      <= (redirect && imem_req && !imem_ack) ? S_DRAIN : S_FETCH;
                        end
                    end else if (ack_acc) begin
                        pf_vld <= 1'b1;
                        pf_dat <= imem_rdata;
                    end
`else
                    if (retire) begin
                        pc    <= next_pc;
                        state <= S_FETCH;
                    end
`endif
                end
                S_DRAIN: begin
                    if (ack_acc)
                        state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
